field_mem_arbiter: RTL and testbench
====================================

FIELD_MEM_ARBITER -- requirements
Module: field_mem_arbiter

Interface
REQ-001 Parameter ADDRW, default 13, SHALL set field address width (80x60 = 4800 cells).
REQ-002 Parameter DATAW, default 96, SHALL set field word width (xn, yn, mag).
REQ-003 Parameter STARVE_LIMIT, default 8, range 1..255, SHALL set the solver starvation threshold in cycles.
REQ-004 Ports SHALL be, in order:
- clk  in  1  single clock.
- rst_n  in  1  reset; asynchronous, active-low.
- draw_req  in  1  VGA draw read request.
- draw_addr  in  ADDRW  draw read address.
- draw_gnt  out  1  draw read accepted this cycle.
- draw_rvalid  out  1  draw read data valid.
- draw_rdata  out  DATAW  draw read data.
- sim_rd_req  in  1  solver read request.
- sim_rd_addr  in  ADDRW  solver read address.
- sim_rd_gnt  out  1  solver read accepted this cycle.
- sim_rvalid  out  1  solver read data valid.
- sim_rdata  out  DATAW  solver read data.
- sim_wr_req  in  1  solver write request.
- sim_wr_addr  in  ADDRW  solver write address.
- sim_wr_data  in  DATAW  solver write data.
- sim_wr_gnt  out  1  solver write accepted this cycle.
- mem_addr_read  out  ADDRW  to field BRAM read address.
- mem_data_out  in  DATAW  from field BRAM, valid one cycle after address.
- mem_we  out  1  BRAM write enable.
- mem_addr_write  out  ADDRW  BRAM write address.
- mem_data_in  out  DATAW  BRAM write data.

Function
REQ-005 The block SHALL grant at most one read per cycle; draw_gnt and sim_rd_gnt SHALL be combinational from the current requests and the registered state, and SHALL never both be 1.
REQ-006 The block SHALL grant draw by default when both requesters ask; it SHALL grant whichever requester asks when only one does.
REQ-007 mem_addr_read SHALL equal the granted requester's address in the grant cycle, and SHALL hold its previous value when no read is granted.
REQ-008 The block SHALL register a one-bit owner tag per grant; draw_rvalid or sim_rvalid SHALL assert exactly one cycle after the matching grant, for exactly one cycle.
REQ-009 draw_rdata and sim_rdata SHALL both be driven from mem_data_out and are meaningful only while the matching rvalid is 1.
REQ-010 Back-to-back grants SHALL sustain one read per cycle, with no bubble between requesters.
REQ-011 Writes SHALL use the independent BRAM write port: sim_wr_gnt = sim_wr_req, mem_we = sim_wr_req, and mem_addr_write/mem_data_in SHALL pass through from the sim_wr inputs.
REQ-012 A read and a write to the same address in the same cycle SHALL return the pre-write data, and the block SHALL NOT stall either access.
REQ-013 Requesters SHALL hold req and addr until granted; deasserting req before grant SHALL cancel the request without error.

Reset
REQ-014 While rst_n = 0, all gnt, rvalid and mem_we outputs SHALL be 0, mem_addr_read SHALL be 0, the owner tag SHALL be 0, and the starvation counter SHALL be 0.
REQ-015 Assertion of rst_n mid-read SHALL discard the pending tag, so no rvalid follows.
REQ-016 The first grant SHALL be possible in the first cycle after rst_n deasserts.

Configuration
REQ-017 With macro FIELD_ARB_STARVE_EN defined, a counter (8 bits, saturating) SHALL increment each cycle in which sim_rd_req = 1 and sim_rd_gnt = 0, and SHALL clear on any sim grant or when sim_rd_req = 0. When the count is >= STARVE_LIMIT, the solver SHALL win the next contention cycle.
REQ-018 Without FIELD_ARB_STARVE_EN, the counter SHALL be absent and draw SHALL have strict priority.

Verification
REQ-019 Draw only: draw_req = 1 with addresses 0..4 on consecutive cycles -> draw_gnt = 1 every cycle and draw_rvalid on cycles 1..5 with BRAM data for addresses 0..4.
REQ-020 Contention: draw_req and sim_rd_req both held for 20 cycles. With STARVE_EN and STARVE_LIMIT = 8, the solver is granted on cycle 8, then every 9th cycle. Without the macro, the solver gets 0 grants.
REQ-021 Alternation: sim-only grant then draw-only grant on consecutive cycles -> sim_rvalid then draw_rvalid on consecutive cycles, with no overlap.
REQ-022 Collision: sim write of 0xA to address 100 while draw reads address 100 (old value 0x5) -> draw_rdata = 0x5; a re-read on the next cycle returns 0xA.
REQ-023 Reset: rst_n pulsed low for 1 cycle right after a grant -> no rvalid follows and all outputs = 0 during reset.

Source files
------------

// File: rtl/field_mem_arbiter.sv
// Field BRAM arbiter: two read requesters (VGA draw, solver) share one BRAM read port; solver writes
// use the independent write port. Define FIELD_ARB_STARVE_EN to add the solver anti-starvation counter.
module field_mem_arbiter #(
   parameter int ADDRW        = 13,
   parameter int DATAW        = 96,
   parameter int STARVE_LIMIT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             draw_req,
   input  logic [ADDRW-1:0] draw_addr,
   output logic             draw_gnt,
   output logic             draw_rvalid,
   output logic [DATAW-1:0] draw_rdata,
   input  logic             sim_rd_req,
   input  logic [ADDRW-1:0] sim_rd_addr,
   output logic             sim_rd_gnt,
   output logic             sim_rvalid,
   output logic [DATAW-1:0] sim_rdata,
   input  logic             sim_wr_req,
   input  logic [ADDRW-1:0] sim_wr_addr,
   input  logic [DATAW-1:0] sim_wr_data,
   output logic             sim_wr_gnt,
   output logic [ADDRW-1:0] mem_addr_read,
   input  logic [DATAW-1:0] mem_data_out,
   output logic             mem_we,
   output logic [ADDRW-1:0] mem_addr_write,
   output logic [DATAW-1:0] mem_data_in
);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
      $error("field_mem_arbiter: STARVE_LIMIT must be 1..255");
   end

   logic             draw_sel;
   logic             sim_sel;
   logic             sim_pri;
   logic [ADDRW-1:0] addr_hold_q, addr_hold_d;
   logic             rd_pend_q, rd_pend_d;
   logic             owner_q, owner_d;

`ifdef FIELD_ARB_STARVE_EN
   logic [7:0] starve_cnt_q, starve_cnt_d;

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!sim_rd_req || sim_sel) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != 8'hFF) begin
         starve_cnt_d = starve_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign sim_pri = (starve_cnt_q >= 8'(STARVE_LIMIT));
`else
   assign sim_pri = 1'b0;
`endif

   // Grants are gated by rst_n so nothing is accepted while reset is held.
   always_comb begin
      draw_sel = 1'b0;
      sim_sel  = 1'b0;
      if (rst_n) begin
         if (draw_req && sim_rd_req) begin
            if (sim_pri) begin
               sim_sel = 1'b1;
            end else begin
               draw_sel = 1'b1;
            end
         end else if (draw_req) begin
            draw_sel = 1'b1;
         end else if (sim_rd_req) begin
            sim_sel = 1'b1;
         end
      end
   end

   always_comb begin
      mem_addr_read = addr_hold_q;
      if (draw_sel) begin
         mem_addr_read = draw_addr;
      end else if (sim_sel) begin
         mem_addr_read = sim_rd_addr;
      end
      addr_hold_d = mem_addr_read;
      rd_pend_d   = draw_sel | sim_sel;
      owner_d     = owner_q;
      if (draw_sel || sim_sel) begin
         owner_d = sim_sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_hold_q <= '0;
         rd_pend_q   <= 1'b0;
         owner_q     <= 1'b0;
      end else begin
         addr_hold_q <= addr_hold_d;
         rd_pend_q   <= rd_pend_d;
         owner_q     <= owner_d;
      end
   end

   assign draw_gnt    = draw_sel;
   assign sim_rd_gnt  = sim_sel;
   assign draw_rvalid = rd_pend_q & ~owner_q;
   assign sim_rvalid  = rd_pend_q & owner_q;
   assign draw_rdata  = mem_data_out;
   assign sim_rdata   = mem_data_out;

   // Write port is never contended; read-first BRAM gives pre-write data on a same-address collision.
   assign sim_wr_gnt     = sim_wr_req & rst_n;
   assign mem_we         = sim_wr_req & rst_n;
   assign mem_addr_write = sim_wr_addr;
   assign mem_data_in    = sim_wr_data;

   a_one_read_gnt: assert property (@(posedge clk) disable iff (!rst_n) !(draw_gnt && sim_rd_gnt));
   a_one_rvalid: assert property (@(posedge clk) disable iff (!rst_n) !(draw_rvalid && sim_rvalid));

endmodule

// File: tb/tb_field_mem_arbiter.sv
// Directed bench for field_mem_arbiter with a read-first BRAM model.
module tb_field_mem_arbiter;
   localparam int AW = 13;
   localparam int DW = 96;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          draw_req;
   logic [AW-1:0] draw_addr;
   logic          draw_gnt;
   logic          draw_rvalid;
   logic [DW-1:0] draw_rdata;
   logic          sim_rd_req;
   logic [AW-1:0] sim_rd_addr;
   logic          sim_rd_gnt;
   logic          sim_rvalid;
   logic [DW-1:0] sim_rdata;
   logic          sim_wr_req;
   logic [AW-1:0] sim_wr_addr;
   logic [DW-1:0] sim_wr_data;
   logic          sim_wr_gnt;
   logic [AW-1:0] mem_addr_read;
   logic [DW-1:0] mem_data_out;
   logic          mem_we;
   logic [AW-1:0] mem_addr_write;
   logic [DW-1:0] mem_data_in;

   always #5 clk = ~clk;

   field_mem_arbiter #(.ADDRW(AW), .DATAW(DW), .STARVE_LIMIT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .draw_req(draw_req), .draw_addr(draw_addr), .draw_gnt(draw_gnt),
      .draw_rvalid(draw_rvalid), .draw_rdata(draw_rdata),
      .sim_rd_req(sim_rd_req), .sim_rd_addr(sim_rd_addr), .sim_rd_gnt(sim_rd_gnt),
      .sim_rvalid(sim_rvalid), .sim_rdata(sim_rdata),
      .sim_wr_req(sim_wr_req), .sim_wr_addr(sim_wr_addr), .sim_wr_data(sim_wr_data),
      .sim_wr_gnt(sim_wr_gnt),
      .mem_addr_read(mem_addr_read), .mem_data_out(mem_data_out), .mem_we(mem_we),
      .mem_addr_write(mem_addr_write), .mem_data_in(mem_data_in)
   );

   bit [DW-1:0] wmem [8192];
   bit          wv   [8192];

   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      if (a == 13'd100) return 96'h5;
      return {16'hC0DE, 3'b000, a, 32'({19'd0, a}) * 32'd7 + 32'd1, 32'hFFFF_0000 ^ {19'd0, a}};
   endfunction

   always @(posedge clk) begin
      mem_data_out <= wv[mem_addr_read] ? wmem[mem_addr_read] : init_word(mem_addr_read);
      if (mem_we) begin
         wmem[mem_addr_write] <= mem_data_in;
         wv[mem_addr_write]   <= 1'b1;
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chka(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic          dr;
      logic [AW-1:0] da;
      logic          sr;
      logic [AW-1:0] sa;
      logic          wr;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          e_dg;
      logic          e_sg;
      logic [AW-1:0] e_ma;
      logic          e_dv;
      logic          e_sv;
      logic [DW-1:0] e_rd;
   } vec_t;

   function automatic vec_t mk(input logic dr, input int da, input logic sr, input int sa,
                               input logic wr, input int wa, input logic [DW-1:0] wd,
                               input logic e_dg, input logic e_sg, input int e_ma,
                               input logic e_dv, input logic e_sv, input logic [DW-1:0] e_rd);
      vec_t v;
      v.dr = dr;  v.da = AW'(da);  v.sr = sr;  v.sa = AW'(sa);
      v.wr = wr;  v.wa = AW'(wa);  v.wd = wd;
      v.e_dg = e_dg;  v.e_sg = e_sg;  v.e_ma = AW'(e_ma);
      v.e_dv = e_dv;  v.e_sv = e_sv;  v.e_rd = e_rd;
      return v;
   endfunction

   task automatic drive(input logic dr, input logic [AW-1:0] da, input logic sr, input logic [AW-1:0] sa,
                        input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      draw_req = dr;  draw_addr = da;
      sim_rd_req = sr;  sim_rd_addr = sa;
      sim_wr_req = wr;  sim_wr_addr = wa;  sim_wr_data = wd;
   endtask

   task automatic chk_all_zero(input string tag);
      chk1({tag, "_draw_gnt"}, draw_gnt, 1'b0);
      chk1({tag, "_sim_rd_gnt"}, sim_rd_gnt, 1'b0);
      chk1({tag, "_sim_wr_gnt"}, sim_wr_gnt, 1'b0);
      chk1({tag, "_mem_we"}, mem_we, 1'b0);
      chk1({tag, "_draw_rvalid"}, draw_rvalid, 1'b0);
      chk1({tag, "_sim_rvalid"}, sim_rvalid, 1'b0);
      chka({tag, "_mem_addr_read"}, mem_addr_read, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
      $fatal(1, "watchdog");
   end

   vec_t vt [18];
   logic starve_build;

   initial begin
`ifdef FIELD_ARB_STARVE_EN
      starve_build = 1'b1;
`else
      starve_build = 1'b0;
`endif
      vt[0]  = mk(1,   0, 0,   0, 0,   0, '0,     1, 0,   0, 0, 0, '0);
      vt[1]  = mk(1,   1, 0,   0, 0,   0, '0,     1, 0,   1, 1, 0, init_word(13'd0));
      vt[2]  = mk(1,   2, 0,   0, 0,   0, '0,     1, 0,   2, 1, 0, init_word(13'd1));
      vt[3]  = mk(1,   3, 0,   0, 0,   0, '0,     1, 0,   3, 1, 0, init_word(13'd2));
      vt[4]  = mk(1,   4, 0,   0, 0,   0, '0,     1, 0,   4, 1, 0, init_word(13'd3));
      vt[5]  = mk(0,   0, 0,   0, 0,   0, '0,     0, 0,   4, 1, 0, init_word(13'd4));
      vt[6]  = mk(0,   0, 1,  20, 0,   0, '0,     0, 1,  20, 0, 0, '0);
      vt[7]  = mk(1,  30, 0,   0, 0,   0, '0,     1, 0,  30, 0, 1, init_word(13'd20));
      vt[8]  = mk(0,   0, 0,   0, 0,   0, '0,     0, 0,  30, 1, 0, init_word(13'd30));
      vt[9]  = mk(1,  40, 1,  41, 0,   0, '0,     1, 0,  40, 0, 0, '0);
      vt[10] = mk(0,   0, 1,  41, 0,   0, '0,     0, 1,  41, 1, 0, init_word(13'd40));
      vt[11] = mk(0,   0, 0,   0, 0,   0, '0,     0, 0,  41, 0, 1, init_word(13'd41));
      vt[12] = mk(1, 100, 0,   0, 1, 100, 96'hA,  1, 0, 100, 0, 0, '0);
      vt[13] = mk(1, 100, 0,   0, 0,   0, '0,     1, 0, 100, 1, 0, 96'h5);
      vt[14] = mk(0,   0, 0,   0, 0,   0, '0,     0, 0, 100, 1, 0, 96'hA);
      vt[15] = mk(0,   0, 1, 200, 1, 201, 96'h77, 0, 1, 200, 0, 0, '0);
      vt[16] = mk(1, 201, 0,   0, 0,   0, '0,     1, 0, 201, 0, 1, init_word(13'd200));
      vt[17] = mk(0,   0, 0,   0, 0,   0, '0,     0, 0, 201, 1, 0, 96'h77);

      // reset held with every request asserted
      rst_n = 1'b0;
      drive(1'b1, 13'd9, 1'b1, 13'd11, 1'b1, 13'd12, 96'h3);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all_zero("in_reset");
      #1;
      drive(1'b1, 13'd3, 1'b0, '0, 1'b0, '0, '0);
      rst_n = 1'b1;
      #1;
      chk1("first_gnt_after_reset", draw_gnt, 1'b1);
      chka("first_gnt_addr", mem_addr_read, 13'd3);
      @(posedge clk); #1;
      chk1("first_rvalid", draw_rvalid, 1'b1);
      chkd("first_rdata", draw_rdata, init_word(13'd3));
      drive(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
      @(posedge clk); #1;

      foreach (vt[i]) begin
         drive(vt[i].dr, vt[i].da, vt[i].sr, vt[i].sa, vt[i].wr, vt[i].wa, vt[i].wd);
         @(negedge clk);
         chk1($sformatf("v%0d_draw_gnt", i), draw_gnt, vt[i].e_dg);
         chk1($sformatf("v%0d_sim_rd_gnt", i), sim_rd_gnt, vt[i].e_sg);
         chka($sformatf("v%0d_mem_addr_read", i), mem_addr_read, vt[i].e_ma);
         chk1($sformatf("v%0d_draw_rvalid", i), draw_rvalid, vt[i].e_dv);
         chk1($sformatf("v%0d_sim_rvalid", i), sim_rvalid, vt[i].e_sv);
         if (vt[i].e_dv) chkd($sformatf("v%0d_draw_rdata", i), draw_rdata, vt[i].e_rd);
         if (vt[i].e_sv) chkd($sformatf("v%0d_sim_rdata", i), sim_rdata, vt[i].e_rd);
         chk1($sformatf("v%0d_mem_we", i), mem_we, vt[i].wr);
         chk1($sformatf("v%0d_sim_wr_gnt", i), sim_wr_gnt, vt[i].wr);
         if (vt[i].wr) begin
            chka($sformatf("v%0d_mem_addr_write", i), mem_addr_write, vt[i].wa);
            chkd($sformatf("v%0d_mem_data_in", i), mem_data_in, vt[i].wd);
         end
         @(posedge clk); #1;
      end

      // sustained contention for 20 cycles, then one idle cycle
      begin
         logic prev_d, prev_s, exp_s, exp_d;
         logic [AW-1:0] exp_ma;
         int sim_cnt;
         prev_d = 1'b0;  prev_s = 1'b0;  sim_cnt = 0;
         exp_ma = 13'd201;
         for (int c = 0; c <= 20; c++) begin
            if (c < 20) drive(1'b1, AW'(500 + c), 1'b1, AW'(600 + c), 1'b0, '0, '0);
            else        drive(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
            exp_s = (c < 20) && starve_build && (c == 8 || c == 17);
            exp_d = (c < 20) && !exp_s;
            if (exp_d) exp_ma = AW'(500 + c);
            if (exp_s) exp_ma = AW'(600 + c);
            @(negedge clk);
            chk1($sformatf("cont%0d_sim_gnt", c), sim_rd_gnt, exp_s);
            chk1($sformatf("cont%0d_draw_gnt", c), draw_gnt, exp_d);
            chka($sformatf("cont%0d_mem_addr_read", c), mem_addr_read, exp_ma);
            chk1($sformatf("cont%0d_draw_rvalid", c), draw_rvalid, prev_d);
            chk1($sformatf("cont%0d_sim_rvalid", c), sim_rvalid, prev_s);
            if (sim_rd_gnt) sim_cnt++;
            prev_d = exp_d;  prev_s = exp_s;
            @(posedge clk); #1;
         end
         chka("cont_sim_grant_count", AW'(sim_cnt), starve_build ? 13'd2 : 13'd0);
      end

      // reset pulse right after a grant discards the pending read
      drive(1'b1, 13'd7, 1'b0, '0, 1'b0, '0, '0);
      @(negedge clk);
      chk1("rst_pre_gnt", draw_gnt, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      drive(1'b1, 13'd8, 1'b1, 13'd9, 1'b1, 13'd10, 96'h1);
      #1;
      chk_all_zero("mid_reset");
      @(posedge clk); #1;
      chk_all_zero("mid_reset_edge");
      rst_n = 1'b1;
      drive(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
      @(negedge clk);
      chk1("post_reset_draw_rvalid_a", draw_rvalid, 1'b0);
      chk1("post_reset_sim_rvalid_a", sim_rvalid, 1'b0);
      @(posedge clk); #1;
      chk1("post_reset_draw_rvalid_b", draw_rvalid, 1'b0);
      chk1("post_reset_sim_rvalid_b", sim_rvalid, 1'b0);
      chka("post_reset_addr", mem_addr_read, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
